// File: rtl/cpu_pkg.sv
// Shared core definitions: fetch-window constants, fetch FSM states and the
// IF/ID pipeline record consumed by the decode stage.
package cpu_pkg;

  localparam int unsigned XLEN         = 32;
  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam int unsigned ROM_BYTES    = 4096;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Pipeline-control and ROM bus bundle between the fetch stage (slave side)
// and the surrounding core / instruction ROM (master side).
interface fetch_stage_if #(
  parameter int WIDTH = 32
);
  logic             stall_i;
  logic             redirect_i;
  logic [WIDTH-1:0] target_i;
  logic [WIDTH-1:0] imem_addr_o;
  logic [WIDTH-1:0] imem_rd_i;
  logic [WIDTH-1:0] instr_o;
  logic [WIDTH-1:0] pc_o;
  logic [WIDTH-1:0] pc_plus4_o;
  logic             valid_o;
  logic             fault_o;
  logic [WIDTH-1:0] fault_addr_o;
  logic [WIDTH-1:0] fetch_count_o;

  modport master (
    output stall_i, redirect_i, target_i, imem_rd_i,
    input  imem_addr_o, instr_o, pc_o, pc_plus4_o, valid_o,
           fault_o, fault_addr_o, fetch_count_o
  );

  modport slave (
    input  stall_i, redirect_i, target_i, imem_rd_i,
    output imem_addr_o, instr_o, pc_o, pc_plus4_o, valid_o,
           fault_o, fault_addr_o, fetch_count_o
  );
endinterface

// File: rtl/fetch_stage_pc_reg.sv
// Program counter with next-PC selection (redirect target or PC+4) and the
// ROM-window legality check; the PC only moves to a legal next address.
module pc_reg #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = cpu_pkg::RESET_VECTOR,
  parameter int unsigned      ROM_BYTES    = cpu_pkg::ROM_BYTES
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             advance_i,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] target_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] npc_o,
  output logic             npc_legal_o
);

  localparam logic [WIDTH-1:0] LAST_ADDR = RESET_VECTOR + WIDTH'(ROM_BYTES) - WIDTH'(4);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] npc;
  logic             npc_legal;

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    npc       = redirect_i ? target_i : pc_q + WIDTH'(4);
    npc_legal = (npc[1:0] == 2'b00) && (npc >= RESET_VECTOR) && (npc <= LAST_ADDR);
    pc_d      = pc_q;
    if (advance_i && npc_legal) begin
      pc_d = npc;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o        = pc_q;
  assign npc_o       = npc;
  assign npc_legal_o = npc_legal;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the ROM address from the PC, fills the IF/ID
// register, and halts with a sticky fault on a misaligned or out-of-window PC.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int               WIDTH        = cpu_pkg::XLEN,
  parameter logic [WIDTH-1:0] RESET_VECTOR = cpu_pkg::RESET_VECTOR,
  parameter int unsigned      ROM_BYTES    = cpu_pkg::ROM_BYTES,
  parameter logic [WIDTH-1:0] NOP_INSTR    = cpu_pkg::NOP_INSTR
) (
  input  logic          clk_i,
  input  logic          rst_i,
  fetch_stage_if.slave  bus
);

  fetch_state_t     state_q, state_d;
  if_id_t           if_id_q, if_id_d;
  logic             fault_q, fault_d;
  logic [WIDTH-1:0] fault_addr_q, fault_addr_d;
  logic [WIDTH-1:0] count_q, count_d;

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] npc;
  logic             npc_legal;
  logic             advance;

  // A next PC is computed on every running edge that is redirected or not stalled.
  assign advance = (state_q == RUN) && (bus.redirect_i || !bus.stall_i);

  pc_reg #(
    .WIDTH        (WIDTH),
    .RESET_VECTOR (RESET_VECTOR),
    .ROM_BYTES    (ROM_BYTES)
  ) u_pc_reg (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .advance_i   (advance),
    .redirect_i  (bus.redirect_i),
    .target_i    (bus.target_i),
    .pc_o        (pc),
    .npc_o       (npc),
    .npc_legal_o (npc_legal)
  );

  always_comb begin
    state_d      = state_q;
    if_id_d      = if_id_q;
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    count_d      = count_q;

    unique case (state_q)
      RUN: begin
        if (bus.redirect_i) begin
          // Flush keeps pc/pc_plus4 so decode still sees the last real PC.
          if_id_d.instr = NOP_INSTR;
          if_id_d.valid = 1'b0;
        end else if (!bus.stall_i) begin
          if_id_d.instr    = bus.imem_rd_i;
          if_id_d.pc       = pc;
          if_id_d.pc_plus4 = pc + WIDTH'(4);
          if_id_d.valid    = 1'b1;
          count_d          = count_q + WIDTH'(1);
        end

        // The current word is still captured on a faulting sequential step,
        // since pc itself was legal; only the move to npc is refused.
        if (advance && !npc_legal) begin
          state_d      = HALT;
          fault_d      = 1'b1;
          fault_addr_d = npc;
        end
      end

      HALT: begin
        if_id_d.instr = NOP_INSTR;
        if_id_d.valid = 1'b0;
      end

      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= RUN;
      if_id_q.instr    <= NOP_INSTR;
      if_id_q.pc       <= '0;
      if_id_q.pc_plus4 <= '0;
      if_id_q.valid    <= 1'b0;
      fault_q          <= 1'b0;
      fault_addr_q     <= '0;
      count_q          <= '0;
    end else begin
      state_q      <= state_d;
      if_id_q      <= if_id_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
      count_q      <= count_d;
    end
  end

  assign bus.imem_addr_o   = pc;
  assign bus.instr_o       = if_id_q.instr;
  assign bus.pc_o          = if_id_q.pc;
  assign bus.pc_plus4_o    = if_id_q.pc_plus4;
  assign bus.valid_o       = if_id_q.valid;
  assign bus.fault_o       = fault_q;
  assign bus.fault_addr_o  = fault_addr_q;
  assign bus.fetch_count_o = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// stall/redirect/reset traffic, all compared against a transaction-level model.
module tb_fetch_stage;

  localparam logic [31:0] RV    = 32'hBFC0_0000;
  localparam int          WORDS = 1024;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_stage_if #(.WIDTH(32)) bus ();

  fetch_stage dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  logic [31:0] rom [WORDS];

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    longint unsigned off;
    off = longint'(addr) - longint'(RV);
    if (addr >= RV && off < longint'(WORDS * 4)) return rom[off / 4];
    return 32'hDEAD_BEEF;
  endfunction

  assign bus.imem_rd_i = rom_word(bus.imem_addr_o);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: the architectural view of the fetch stage.
  logic [31:0] m_pc, m_instr, m_pc_o, m_p4, m_faddr, m_count;
  logic        m_valid, m_fault, m_halt;

  function automatic bit in_window(input logic [31:0] a);
    return (a % 4 == 0) && (a >= RV) && ((longint'(a) - longint'(RV)) < longint'(WORDS * 4));
  endfunction

  task automatic model_step(input logic r, input logic s, input logic d, input logic [31:0] t);
    logic [31:0] next_pc;
    bit          tried;
    tried = 0;
    next_pc = '0;
    if (r) begin
      m_pc = RV; m_halt = 0; m_instr = NOP; m_pc_o = 0; m_p4 = 0;
      m_valid = 0; m_fault = 0; m_faddr = 0; m_count = 0;
    end else if (m_halt) begin
      m_instr = NOP;
      m_valid = 0;
    end else begin
      if (d) begin
        next_pc = t; tried = 1;
        m_instr = NOP; m_valid = 0;
      end else if (!s) begin
        m_instr = rom_word(m_pc); m_pc_o = m_pc; m_p4 = m_pc + 4;
        m_valid = 1; m_count = m_count + 1;
        next_pc = m_pc + 4; tried = 1;
      end
      if (tried) begin
        if (in_window(next_pc)) m_pc = next_pc;
        else begin
          m_halt = 1; m_fault = 1; m_faddr = next_pc;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("imem_addr", bus.imem_addr_o, m_pc);
    check("instr", bus.instr_o, m_instr);
    check("pc", bus.pc_o, m_pc_o);
    check("pc_plus4", bus.pc_plus4_o, m_p4);
    check("valid", 32'(bus.valid_o), 32'(m_valid));
    check("fault", 32'(bus.fault_o), 32'(m_fault));
    check("fault_addr", bus.fault_addr_o, m_faddr);
    check("fetch_count", bus.fetch_count_o, m_count);
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic step(input logic r, input logic s, input logic d, input logic [31:0] t);
    rst = r;
    bus.stall_i = s;
    bus.redirect_i = d;
    bus.target_i = t;
    @(posedge clk);
    model_step(r, s, d, t);
    #1;
    compare_all();
  endtask

  initial begin
    logic [31:0] tgt;
    int          sel;
    for (int i = 0; i < WORDS; i++) rom[i] = $urandom;
    rom[0] = 32'h0050_0093;
    rom[1] = 32'h0010_8113;
    rst = 1'b1;
    bus.stall_i = 1'b0;
    bus.redirect_i = 1'b0;
    bus.target_i = '0;

    step(1, 0, 0, 0);
    check("rst_addr", bus.imem_addr_o, RV);
    check("rst_instr", bus.instr_o, NOP);
    check("rst_valid", 32'(bus.valid_o), 0);

    step(0, 0, 0, 0);
    check("first_instr", bus.instr_o, 32'h0050_0093);
    check("first_pc", bus.pc_o, RV);
    check("first_pc4", bus.pc_plus4_o, RV + 4);
    check("first_valid", 32'(bus.valid_o), 1);
    step(0, 0, 0, 0);
    check("second_instr", bus.instr_o, 32'h0010_8113);
    check("second_count", bus.fetch_count_o, 2);

    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0);
      check("stall_addr", bus.imem_addr_o, RV + 8);
      check("stall_instr", bus.instr_o, 32'h0010_8113);
      check("stall_count", bus.fetch_count_o, 2);
    end
    step(0, 0, 0, 0);
    check("resume_pc", bus.pc_o, RV + 8);

    step(0, 1, 1, RV + 32'h100);
    check("redir_addr", bus.imem_addr_o, RV + 32'h100);
    check("redir_valid", 32'(bus.valid_o), 0);
    check("redir_instr", bus.instr_o, NOP);
    step(0, 0, 0, 0);
    check("redir_capture", bus.instr_o, rom[64]);
    check("redir_cap_valid", 32'(bus.valid_o), 1);

    step(0, 0, 1, RV + 32'h102);
    check("mis_fault", 32'(bus.fault_o), 1);
    check("mis_faddr", bus.fault_addr_o, RV + 32'h102);
    check("mis_pc_hold", bus.imem_addr_o, RV + 32'h104);
    check("mis_valid", 32'(bus.valid_o), 0);
    step(0, 0, 1, RV + 32'h200);
    check("halt_ignore", bus.imem_addr_o, RV + 32'h104);

    step(1, 0, 0, 0);
    step(0, 0, 1, RV + 32'hFFC);
    check("edge_addr", bus.imem_addr_o, RV + 32'hFFC);
    step(0, 0, 0, 0);
    check("edge_capture", bus.instr_o, rom[WORDS-1]);
    check("edge_valid", 32'(bus.valid_o), 1);
    check("edge_fault", 32'(bus.fault_o), 1);
    check("edge_faddr", bus.fault_addr_o, RV + 32'h1000);
    step(0, 0, 0, 0);
    check("edge_bubble", 32'(bus.valid_o), 0);

    step(1, 0, 0, 0);
    check("halt_rst_fault", 32'(bus.fault_o), 0);
    check("halt_rst_addr", bus.imem_addr_o, RV);
    check("halt_rst_count", bus.fetch_count_o, 0);

    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(0, 15);
      case (sel)
        0:       tgt = $urandom;
        1:       tgt = RV + ($urandom_range(0, WORDS - 1) << 2) + $urandom_range(1, 3);
        2:       tgt = RV + WORDS * 4;
        3:       tgt = RV - 4;
        default: tgt = RV + ($urandom_range(0, WORDS - 1) << 2);
      endcase
      step(($urandom_range(0, m_halt ? 15 : 199) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 9) == 0),
           tgt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the RISC-V core; sits directly upstream of the instruction ROM.
- Owns the program counter, drives the ROM byte address, and captures the returned 32-bit instruction into the IF/ID pipeline register.
- Handles stall, branch/jump redirect and flush, and detects fetch faults: a misaligned PC or a PC outside the ROM window.

Parameters:
- WIDTH, 32, address/data width.
- RESET_VECTOR, 32'hBFC00000, PC value after reset; also the ROM base.
- ROM_BYTES, 4096, ROM window size in bytes; last legal fetch address is RESET_VECTOR+ROM_BYTES-4.
- NOP_INSTR, 32'h00000013, bubble encoding (addi x0,x0,0).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- stall_i  in  1  hold PC and IF/ID register.
- redirect_i  in  1  take target_i as next PC (branch taken / jal / jalr).
- target_i  in  WIDTH  redirect target address.
- imem_addr_o  out  WIDTH  byte address to ROM; equals pc_q, combinational.
- imem_rd_i  in  WIDTH  instruction returned combinationally by ROM.
- instr_o  out  WIDTH  IF/ID instruction.
- pc_o  out  WIDTH  IF/ID PC of instr_o.
- pc_plus4_o  out  WIDTH  IF/ID pc_o+4, for link-register writes.
- valid_o  out  1  IF/ID holds a real instruction.
- fault_o  out  1  sticky fetch-fault flag.
- fault_addr_o  out  WIDTH  offending next-PC address.
- fetch_count_o  out  WIDTH  number of valid instructions captured.

Behaviour:
- States: RUN, HALT.
- Reset (rst_i=1 at edge), which overrides everything:
  - state=RUN, pc_q=RESET_VECTOR, instr_o=NOP_INSTR, pc_o=0, pc_plus4_o=0.
  - valid_o=0, fault_o=0, fault_addr_o=0, fetch_count_o=0.
- Legality check on next PC (npc): legal iff npc[1:0]==0 and RESET_VECTOR <= npc <= RESET_VECTOR+ROM_BYTES-4. Comparisons are unsigned, WIDTH bits; PC+4 wraps modulo 2^WIDTH.
- RUN priority per edge is redirect_i > stall_i > sequential.
  - redirect_i=1, regardless of stall_i:
    - npc=target_i.
    - IF/ID is flushed: instr_o=NOP_INSTR, valid_o=0, pc_o/pc_plus4_o hold.
    - Count unchanged.
  - stall_i=1 and redirect_i=0: pc_q, IF/ID and count all hold.
  - Otherwise:
    - IF/ID captures instr_o=imem_rd_i, pc_o=pc_q, pc_plus4_o=pc_q+4, valid_o=1.
    - npc=pc_q+4; fetch_count_o increments, wrapping.
  - Whenever an npc is computed (redirect or sequential):
    - If npc is legal, pc_q<=npc.
    - If npc is illegal: pc_q holds, state<=HALT, fault_o<=1, fault_addr_o<=npc.
    - On the sequential path, the current instruction is still captured valid, because pc_q itself was legal.
- HALT:
  - pc_q, fault_o and fault_addr_o hold.
  - IF/ID loads NOP_INSTR with valid_o=0 on the first HALT edge and stays there.
  - stall_i and redirect_i are ignored; only rst_i exits.
- Latency:
  - The instruction at PC p appears on instr_o one edge after pc_q==p, provided that edge is not stalled or redirected.
  - A redirect costs one bubble cycle.
- First fetch: the first non-stalled edge after reset captures the word at RESET_VECTOR.
- Reset mid-operation (including while in HALT): next state is identical to a power-on reset.

Decomposition:
- Shared package cpu_pkg:
  - RESET_VECTOR, ROM_BYTES, NOP_INSTR constants.
  - fetch_state_t enum {RUN, HALT}.
  - if_id_t struct {instr, pc, pc_plus4, valid}, reused by the decode stage.
- One natural sub-module, pc_reg: the PC register with next-PC mux and legality check, outputting npc_legal.
- The IF/ID register and counter stay in fetch_stage.

Test Plan:
- Reset then free-run, ROM words 0x00500093, 0x00108113 at 0xBFC00000/04:
  - edge 1: instr_o=0x00500093, pc_o=0xBFC00000, pc_plus4_o=0xBFC00004, valid_o=1.
  - edge 2: instr_o=0x00108113, fetch_count_o=2.
- stall_i=1 for 3 cycles at pc_q=0xBFC00008 -> imem_addr_o, instr_o and fetch_count_o unchanged for 3 cycles; resumes at 0xBFC00008.
- redirect_i=1 with stall_i=1, target_i=0xBFC00100 -> next cycle imem_addr_o=0xBFC00100, valid_o=0, instr_o=0x00000013; following edge captures the word at 0xBFC00100 valid.
- redirect_i with target_i=0xBFC00102 -> fault_o=1, fault_addr_o=0xBFC00102, pc_q unchanged, valid_o=0 after one edge; later redirects ignored.
- Sequential fetch at pc_q=0xBFC00FFC -> that instruction captured valid_o=1; fault_o=1, fault_addr_o=0xBFC01000; next edge valid_o=0.
- rst_i=1 while in HALT -> next edge fault_o=0, imem_addr_o=0xBFC00000, fetch_count_o=0, valid_o=0.
